// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: button-driven direction controller for a snake game.
//   Synchronizes a divided 2 ms square wave into a one-clk tick, debounces
//   four direction buttons on that tick, arbitrates press events into a
//   pending direction (rejecting 180-degree reversals), and generates
//   periodic step pulses that commit the pending direction.
// Ports:
//   clk        system clock (only clock)
//   rst        synchronous active-high reset
//   clk_2ms    divided square wave, sampled as data
//   btn_up/down/left/right  raw asynchronous active-high buttons
//   speed[1:0] step period = MOVE_TICKS >> speed ticks (minimum 1)
//   run        step generation enable
//   dir[1:0]   committed direction: 00 up, 01 down, 10 left, 11 right
//   move       one-clk step pulse
//   dir_chg    one-clk pulse with move when the committed direction changes
module snake_dir_ctrl #(
  parameter int unsigned DEBOUNCE_N = 5,
  parameter int unsigned MOVE_TICKS = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_2ms,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [1:0] speed,
  input  logic       run,
  output logic [1:0] dir,
  output logic       move,
  output logic       dir_chg
);

  localparam int unsigned DW     = $clog2(DEBOUNCE_N + 1);
  localparam int unsigned W      = $clog2(MOVE_TICKS + 1);
  localparam int unsigned NBTN   = 4;
  localparam logic [1:0]  DIR_RT = 2'b11;

  // Button index equals its direction code: 0 up, 1 down, 2 left, 3 right.
  logic [NBTN-1:0] w_btn_raw;
  assign w_btn_raw = {btn_right, btn_left, btn_down, btn_up};

  logic            r_clk_s1, r_clk_s2, r_clk_s3, r_tick;
  logic [NBTN-1:0] r_btn_s1, r_btn_s2;
  logic [NBTN-1:0] r_stable, r_stable_d;
  logic [DW-1:0]   r_db_cnt [NBTN];
  logic [W-1:0]    r_step_cnt;
  logic [1:0]      r_dir, r_next_dir;
  logic            r_move, r_dir_chg;

  logic [NBTN-1:0] w_press;
  logic            w_take;
  logic [1:0]      w_take_dir;
  logic [1:0]      w_next_dir_d;
  logic [W-1:0]    w_period_raw, w_period, w_period_m1;
  logic            w_fire;

  // Synchronizers and tick: rising edge of the synchronized wave, registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1 <= 1'b0;
      r_clk_s2 <= 1'b0;
      r_clk_s3 <= 1'b0;
      r_tick   <= 1'b0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
    end else begin
      r_clk_s1 <= clk_2ms;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_tick   <= r_clk_s2 & ~r_clk_s3;
      r_btn_s1 <= w_btn_raw;
      r_btn_s2 <= r_btn_s1;
    end
  end

  // Debounce: a level change must persist for DEBOUNCE_N consecutive ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < NBTN; i++) r_db_cnt[i] <= '0;
    end else begin
      r_stable_d <= r_stable;
      if (r_tick) begin
        for (int i = 0; i < NBTN; i++) begin
          if (r_btn_s2[i] == r_stable[i]) begin
            r_db_cnt[i] <= '0;
          end else if (r_db_cnt[i] == DW'(DEBOUNCE_N - 1)) begin
            r_stable[i] <= ~r_stable[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
          end
        end
      end
    end
  end

  // Press events are stable 0->1 flips only.
  assign w_press = r_stable & ~r_stable_d;

  // Fixed priority (lowest index wins) and reversal rejection against committed dir.
  always_comb begin
    w_take       = 1'b0;
    w_take_dir   = 2'b00;
    w_next_dir_d = r_next_dir;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (w_press[i]) begin
        w_take     = 1'b1;
        w_take_dir = 2'(i);
      end
    end
    // Opposite direction differs only in bit 0.
    if (w_take && (w_take_dir != {r_dir[1], ~r_dir[0]})) begin
      w_next_dir_d = w_take_dir;
    end
  end

  // Step period with a floor of one tick.
  always_comb begin
    w_period_raw = W'(MOVE_TICKS) >> speed;
    w_period     = (w_period_raw == '0) ? W'(1) : w_period_raw;
    w_period_m1  = w_period - W'(1);
    // >= lets a speed increase fire on the very next tick.
    w_fire       = r_tick && run && (r_step_cnt >= w_period_m1);
  end

  // Step counter, step pulse and direction commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_cnt <= '0;
      r_move     <= 1'b0;
      r_dir_chg  <= 1'b0;
      r_dir      <= DIR_RT;
      r_next_dir <= DIR_RT;
    end else begin
      if (!run) begin
        r_step_cnt <= '0;
      end else if (r_tick) begin
        r_step_cnt <= w_fire ? '0 : (r_step_cnt + W'(1));
      end
      r_move     <= w_fire;
      r_dir_chg  <= w_fire && (w_next_dir_d != r_dir);
      r_next_dir <= w_next_dir_d;
      // dir takes the pending value at the end of the move cycle.
      if (r_move) begin
        r_dir <= r_next_dir;
      end
    end
  end

  assign dir     = r_dir;
  assign move    = r_move;
  assign dir_chg = r_dir_chg;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed self-checking bench for snake_dir_ctrl (DEBOUNCE_N=3, MOVE_TICKS=8,
// clk_2ms period of 10 clk). Button changes are applied at clk_2ms rising
// edges so each new level is the one sampled by the tick of that rise.
module tb_snake_dir_ctrl;

  logic       clk, rst, clk_2ms;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic [1:0] speed;
  logic       run;
  logic [1:0] dir;
  logic       move, dir_chg;

  int total, bad;
  int tick_no, cyc;
  int move_cnt, chg_cnt, stray;
  int last_move_tick, last_move_cyc, move_gap;
  logic last_move_chg;
  int base;

  snake_dir_ctrl #(.DEBOUNCE_N(3), .MOVE_TICKS(8)) dut (
    .clk(clk), .rst(rst), .clk_2ms(clk_2ms),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .speed(speed), .run(run), .dir(dir), .move(move), .dir_chg(dir_chg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Divided wave: 5 clk low, 5 clk high, changed on falling clk edges.
  initial begin
    clk_2ms = 1'b0;
    tick_no = 0;
    forever begin
      repeat (5) @(negedge clk);
      clk_2ms = ~clk_2ms;
      if (clk_2ms) tick_no++;
    end
  end

  always @(posedge clk) cyc++;

  // Observer: records every step pulse and the tick window it fell in.
  always @(negedge clk) begin
    if (move) begin
      move_cnt++;
      if (dir_chg) chg_cnt++;
      move_gap       = cyc - last_move_cyc;
      last_move_cyc  = cyc;
      last_move_tick = tick_no;
      last_move_chg  = dir_chg;
    end else if (dir_chg) begin
      stray++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic tick_wait(input int n);
    repeat (n) @(posedge clk_2ms);
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk_2ms);
    rst = 1'b1;
    @(negedge clk);
    total++; if (dir !== 2'b11) begin bad++; $display("FAIL rst_dir: got %0d want 3", dir); end
    total++; if (move !== 1'b0 || dir_chg !== 1'b0) begin bad++; $display("FAIL rst_pulse: got move=%0b chg=%0b want 0/0", move, dir_chg); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (move !== 1'b0 || dir_chg !== 1'b0) begin bad++; $display("FAIL post_rst_pulse: got move=%0b chg=%0b want 0/0", move, dir_chg); end
    base = tick_no;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (dir !== 2'b11) begin bad++; $display("FAIL reset_dir_after: got %0d want 3", dir); end
  endtask

  // No buttons: step every 8 ticks (80 clk), direction stays right.
  task automatic test_free_run();
    int mv, ch;
    mv = move_cnt; ch = chg_cnt;
    tick_wait(24); settle();
    total++; if (move_cnt - mv != 3) begin bad++; $display("FAIL free_moves: got %0d want 3", move_cnt - mv); end
    total++; if (last_move_tick != base + 24) begin bad++; $display("FAIL free_tick: got %0d want %0d", last_move_tick - base, 24); end
    total++; if (move_gap != 80) begin bad++; $display("FAIL free_gap: got %0d want 80", move_gap); end
    total++; if (chg_cnt != ch) begin bad++; $display("FAIL free_chg: got %0d want %0d", chg_cnt, ch); end
    total++; if (dir !== 2'b11) begin bad++; $display("FAIL free_dir: got %0d want 3", dir); end
  endtask

  // Up held 3 ticks: one press, next step turns up with dir_chg, then no change.
  task automatic test_press();
    int mv;
    mv = move_cnt;
    tick_wait(1); btn_up = 1'b1;
    tick_wait(3); btn_up = 1'b0;
    tick_wait(4); settle();
    total++; if (move_cnt - mv != 1) begin bad++; $display("FAIL press_moves: got %0d want 1", move_cnt - mv); end
    total++; if (last_move_tick != base + 32) begin bad++; $display("FAIL press_tick: got %0d want 32", last_move_tick - base); end
    total++; if (last_move_chg !== 1'b1) begin bad++; $display("FAIL press_chg: got %0b want 1", last_move_chg); end
    total++; if (dir !== 2'b00) begin bad++; $display("FAIL press_dir: got %0d want 0", dir); end
    tick_wait(8); settle();
    total++; if (last_move_tick != base + 40) begin bad++; $display("FAIL press_tick2: got %0d want 40", last_move_tick - base); end
    total++; if (last_move_chg !== 1'b0) begin bad++; $display("FAIL press_chg2: got %0b want 0", last_move_chg); end
    total++; if (dir !== 2'b00) begin bad++; $display("FAIL press_dir2: got %0d want 0", dir); end
  endtask

  // Left glitch 2 high, 1 low, 2 high never reaches 3 consecutive samples.
  task automatic test_glitch();
    tick_wait(1); btn_left = 1'b1;
    tick_wait(2); btn_left = 1'b0;
    tick_wait(1); btn_left = 1'b1;
    tick_wait(2); btn_left = 1'b0;
    tick_wait(2); settle();
    total++; if (last_move_tick != base + 48) begin bad++; $display("FAIL glitch_tick: got %0d want 48", last_move_tick - base); end
    total++; if (last_move_chg !== 1'b0) begin bad++; $display("FAIL glitch_chg: got %0b want 0", last_move_chg); end
    total++; if (dir !== 2'b00) begin bad++; $display("FAIL glitch_dir: got %0d want 0", dir); end
  endtask

  // Left while right is discarded; up then down before a step yields down,
  // since down is checked against committed right, not pending up.
  task automatic test_reversal();
    do_reset();
    tick_wait(1); btn_left = 1'b1;
    tick_wait(3); btn_left = 1'b0;
    tick_wait(4); settle();
    total++; if (last_move_tick != base + 8) begin bad++; $display("FAIL rev_tick: got %0d want 8", last_move_tick - base); end
    total++; if (dir !== 2'b11 || last_move_chg !== 1'b0) begin bad++; $display("FAIL rev_discard: got dir=%0d chg=%0b want 3/0", dir, last_move_chg); end
    tick_wait(1); btn_up = 1'b1;
    tick_wait(3); btn_up = 1'b0; btn_down = 1'b1;
    tick_wait(3); btn_down = 1'b0;
    tick_wait(1); settle();
    total++; if (last_move_tick != base + 16) begin bad++; $display("FAIL rev_tick2: got %0d want 16", last_move_tick - base); end
    total++; if (dir !== 2'b01 || last_move_chg !== 1'b1) begin bad++; $display("FAIL rev_overwrite: got dir=%0d chg=%0b want 1/1", dir, last_move_chg); end
  endtask

  // Up and right together: up wins. Speed 0->2 at count 5 fires next tick.
  task automatic test_priority_speed();
    int mv;
    do_reset();
    tick_wait(1); btn_up = 1'b1; btn_right = 1'b1;
    tick_wait(3); btn_up = 1'b0; btn_right = 1'b0;
    tick_wait(2); speed = 2'd2;
    settle();
    total++; if (last_move_tick != base + 6) begin bad++; $display("FAIL spd_tick: got %0d want 6", last_move_tick - base); end
    total++; if (dir !== 2'b00 || last_move_chg !== 1'b1) begin bad++; $display("FAIL prio_dir: got dir=%0d chg=%0b want 0/1", dir, last_move_chg); end
    mv = move_cnt;
    tick_wait(4); settle();
    total++; if (move_cnt - mv != 2) begin bad++; $display("FAIL spd_moves: got %0d want 2", move_cnt - mv); end
    total++; if (last_move_tick != base + 10) begin bad++; $display("FAIL spd_tick2: got %0d want 10", last_move_tick - base); end
    total++; if (move_gap != 20) begin bad++; $display("FAIL spd_gap: got %0d want 20", move_gap); end
  endtask

  // run low 20 ticks: no steps, pending direction still updates; first step
  // on the 8th tick after run rises.
  task automatic test_run_gate();
    int mv;
    speed = 2'd0;
    tick_wait(1); run = 1'b0;
    mv = move_cnt;
    tick_wait(1); btn_left = 1'b1;
    tick_wait(3); btn_left = 1'b0;
    tick_wait(16); run = 1'b1;
    total++; if (move_cnt != mv) begin bad++; $display("FAIL run_low_moves: got %0d want 0", move_cnt - mv); end
    tick_wait(7); settle();
    total++; if (move_cnt - mv != 1) begin bad++; $display("FAIL run_first_moves: got %0d want 1", move_cnt - mv); end
    total++; if (last_move_tick != base + 38) begin bad++; $display("FAIL run_first_tick: got %0d want 38", last_move_tick - base); end
    total++; if (dir !== 2'b10 || last_move_chg !== 1'b1) begin bad++; $display("FAIL run_dir: got dir=%0d chg=%0b want 2/1", dir, last_move_chg); end
  endtask

  // Reset mid-count and mid-debounce with up held through reset.
  task automatic test_reset_mid();
    int mv;
    tick_wait(2); btn_up = 1'b1;
    tick_wait(1);
    mv = move_cnt;
    do_reset();
    tick_wait(7);
    total++; if (move_cnt != mv) begin bad++; $display("FAIL rmid_early: got %0d want 0", move_cnt - mv); end
    tick_wait(1); settle();
    btn_up = 1'b0;
    total++; if (last_move_tick != base + 8) begin bad++; $display("FAIL rmid_tick: got %0d want 8", last_move_tick - base); end
    total++; if (dir !== 2'b00 || last_move_chg !== 1'b1) begin bad++; $display("FAIL rmid_held: got dir=%0d chg=%0b want 0/1", dir, last_move_chg); end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    move_cnt = 0; chg_cnt = 0; stray = 0;
    last_move_tick = 0; last_move_cyc = 0; move_gap = 0; last_move_chg = 1'b0;
    base = 0;
    rst = 1'b1; run = 1'b1; speed = 2'd0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    test_reset();
    test_free_run();
    test_press();
    test_glitch();
    test_reversal();
    test_priority_speed();
    test_run_gate();
    test_reset_mid();
    total++; if (stray != 0) begin bad++; $display("FAIL stray_chg: got %0d want 0", stray); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
